// File: rtl/bm_dl_seq_chunked_adder_with_flags_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// FSM state encoding, default widths and counter sizing live here.
package bm_dl_seq_chunked_adder_with_flags_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_N     = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int num_chunks(input int n, input int chunk);
    return n / chunk;
  endfunction

  // A single-chunk build still needs a 1-bit counter to keep the port widths legal.
  function automatic int cnt_width(input int nc);
    return (nc > 1) ? $clog2(nc) : 1;
  endfunction

endpackage

// File: rtl/bm_dl_chunk_adder.sv
// W-bit combinational adder slice: sum, carry-out and carry into the slice MSB.
// Zero latency; no flow control.
module bm_dl_chunk_adder
  import bm_dl_seq_chunked_adder_with_flags_pkg::*;
#(
  parameter int W = DEF_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum   = full[W-1:0];
  assign cout  = full[W];
  // Carry into the MSB falls out of the MSB sum bit without a second adder.
  assign c_msb = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/bm_dl_seq_chunked_adder_with_flags.sv
// Sequential N-bit adder, CHUNK bits per cycle, carry/overflow flags; optional SUBTRACT_MODE_EN adds `sub`.
// Latency N/CHUNK cycles from accepted start to done; start is ignored while busy (not queued).
module bm_dl_seq_chunked_adder_with_flags
  import bm_dl_seq_chunked_adder_with_flags_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         carryin,
`ifdef SUBTRACT_MODE_EN
  input  logic         sub,
`endif
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         carryout,
  output logic         overflow
);

  localparam int NC = num_chunks(N, CHUNK);
  localparam int CW = cnt_width(NC);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     xr, yr, psum, sum_full;
  logic             carry;
  logic             last, accept, b_inv;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             cout_chunk, cmsb_chunk;

`ifdef SUBTRACT_MODE_EN
  assign b_inv = sub;
`else
  assign b_inv = 1'b0;
`endif

  assign last   = (cnt == CW'(NC - 1));
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  assign a_chunk = xr[cnt*CHUNK +: CHUNK];
  assign b_chunk = yr[cnt*CHUNK +: CHUNK];

  bm_dl_chunk_adder #(.W(CHUNK)) u_chunk (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (carry),
    .sum   (sum_chunk),
    .cout  (cout_chunk),
    .c_msb (cmsb_chunk)
  );

  always_comb begin
    sum_full = psum;
    sum_full[cnt*CHUNK +: CHUNK] = sum_chunk;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is folded in at latch time so the run loop is a plain add.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xr       <= '0;
      yr       <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      S        <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      xr    <= X;
      yr    <= Y ^ {N{b_inv}};
      carry <= carryin ^ b_inv;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      psum  <= sum_full;
      carry <= cout_chunk;
      cnt   <= cnt + 1'b1;
      if (last) begin
        S        <= sum_full;
        carryout <= cout_chunk;
        overflow <= cout_chunk ^ cmsb_chunk;
      end
    end
  end

endmodule

// File: tb/tb_bm_dl_seq_chunked_adder_with_flags.sv
// Directed bench for the chunked adder: arithmetic model compared every cycle plus literal vectors.
module tb_bm_dl_seq_chunked_adder_with_flags;

  localparam int N  = 32;
  localparam int NC = N / 8;

  logic         clock = 1'b0;
  logic         reset, start, start32, carryin;
  logic [N-1:0] X, Y;
  logic         busy, done, carryout, overflow;
  logic [N-1:0] S;
  logic         busy32, done32, co32, ov32;
  logic [N-1:0] S32;
  logic         msub;
`ifdef SUBTRACT_MODE_EN
  logic         sub;
  assign msub = sub;
`else
  assign msub = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clock = ~clock;

  bm_dl_seq_chunked_adder_with_flags #(.N(N), .CHUNK(8)) dut (
    .clock(clock), .reset(reset), .start(start), .carryin(carryin),
`ifdef SUBTRACT_MODE_EN
    .sub(sub),
`endif
    .X(X), .Y(Y), .busy(busy), .done(done), .S(S),
    .carryout(carryout), .overflow(overflow)
  );

  bm_dl_seq_chunked_adder_with_flags #(.N(N), .CHUNK(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .carryin(carryin),
`ifdef SUBTRACT_MODE_EN
    .sub(sub),
`endif
    .X(X), .Y(Y), .busy(busy32), .done(done32), .S(S32),
    .carryout(co32), .overflow(ov32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: remaining run cycles plus the exact arithmetic result of the accepted operands.
  int           m_left = 0;
  logic         m_done = 1'b0, m_co = 1'b0, m_ov = 1'b0;
  logic [N-1:0] m_s = '0, p_s = '0;
  logic         p_co = 1'b0, p_ov = 1'b0;
  logic         m_acc, m_ci;
  logic [N-1:0] m_b;
  logic [N:0]   m_tot;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_s = '0; m_co = 1'b0; m_ov = 1'b0;
    end else begin
      m_acc  = (m_left == 0) && start;
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_s = p_s; m_co = p_co; m_ov = p_ov;
        end
      end
      if (m_acc) begin
        m_b    = msub ? ~Y : Y;
        m_ci   = carryin ^ msub;
        m_tot  = {1'b0, X} + {1'b0, m_b} + {{N{1'b0}}, m_ci};
        p_s    = m_tot[N-1:0];
        p_co   = m_tot[N];
        p_ov   = (X[N-1] == m_b[N-1]) && (p_s[N-1] != X[N-1]);
        m_left = NC;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_left > 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_S", 64'(S), 64'(m_s));
      chk("cyc_co", 64'(carryout), 64'(m_co));
      chk("cyc_ov", 64'(overflow), 64'(m_ov));
    end
  end

  task automatic wait_done(input string nm, input logic use32, output int cyc, output int bcnt);
    bit seen;
    seen = 0; cyc = 0; bcnt = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      cyc++;
      if (use32 ? busy32 : busy) bcnt++;
      if (use32 ? done32 : done) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic sb, input logic [31:0] es, input logic eco,
                        input logic eov, input string nm);
    int cyc, bcnt;
    @(posedge clock); #2;
    X = x; Y = y; carryin = ci;
`ifdef SUBTRACT_MODE_EN
    sub = sb;
`else
    if (sb) chk({nm, "_sub_unsupported"}, 64'(0), 64'(1));
`endif
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0; X = $urandom; Y = $urandom; carryin = ~ci;
    wait_done(nm, 1'b0, cyc, bcnt);
    chk({nm, "_S"}, 64'(S), 64'(es));
    chk({nm, "_co"}, 64'(carryout), 64'(eco));
    chk({nm, "_ov"}, 64'(overflow), 64'(eov));
    chk({nm, "_lat"}, 64'(cyc - 1), 64'(NC));
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(NC));
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic [31:0] es, input logic eco, input logic eov, input string nm);
    int cyc, bcnt;
    @(posedge clock); #2;
    X = x; Y = y; carryin = ci; start32 = 1'b1;
    @(posedge clock); #2;
    start32 = 1'b0;
    wait_done(nm, 1'b1, cyc, bcnt);
    chk({nm, "_S"}, 64'(S32), 64'(es));
    chk({nm, "_co"}, 64'(co32), 64'(eco));
    chk({nm, "_ov"}, 64'(ov32), 64'(eov));
    chk({nm, "_lat"}, 64'(cyc - 1), 64'(1));
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(1));
  endtask

  initial begin
    int cyc, bcnt, dcnt;
    reset = 1'b1; start = 1'b0; start32 = 1'b0; carryin = 1'b0; X = '0; Y = '0;
`ifdef SUBTRACT_MODE_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_S", 64'(S), 64'(0));
    chk("rst_co", 64'(carryout), 64'(0));
    chk("rst_ov", 64'(overflow), 64'(0));
    @(posedge clock); #2;
    reset = 1'b0; cmp_en = 1'b1;

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "t1_wrap");
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "t2_posov");
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, "t2_negov");
    run_op(32'h000000FF, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 1'b0, 1'b0, "t3_xchunk");
    run32(32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0, 1'b0, "t3_c32");
    run32(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "t3_c32_ov");

    // Reset in the middle of a run: abandoned, no done.
    @(posedge clock); #2;
    X = 32'h12345678; Y = 32'h11111111; carryin = 1'b0; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    @(posedge clock); @(posedge clock); #3;
    reset = 1'b1; #1;
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_done", 64'(done), 64'(0));
    chk("t4_S", 64'(S), 64'(0));
    @(posedge clock); #2;
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    chk("t4_no_done", 64'(dcnt), 64'(0));
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, "t4_after");

    // start held through RUN, then re-accepted in the DONE cycle.
    @(posedge clock); #2;
    X = 32'd1; Y = 32'd2; carryin = 1'b0; start = 1'b1;
    @(posedge clock); #2;
    X = 32'd10; Y = 32'd20;
    wait_done("t5_first", 1'b0, cyc, bcnt);
    chk("t5_first_S", 64'(S), 64'(3));
    chk("t5_first_lat", 64'(cyc - 1), 64'(NC));
    @(posedge clock); #2;
    start = 1'b0;
    @(negedge clock);
    chk("t5_b2b_busy", 64'(busy), 64'(1));
    chk("t5_held_S", 64'(S), 64'(3));
    wait_done("t5_second", 1'b0, cyc, bcnt);
    chk("t5_second_S", 64'(S), 64'(30));
    @(negedge clock);
    chk("t5_not_queued", 64'(busy), 64'(0));

`ifdef SUBTRACT_MODE_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "t6_sub");
    run_op(32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "t6_subov");
    run_op(32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0, "t6_add");
`endif

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
